syncnt_updn: RTL

SYNCNT_UPDN -- requirements
Module: syncnt_updn

---
 rtl/syncnt_updn.sv | 81 ++++++++
 1 files changed

// File: rtl/syncnt_updn.sv
// Synchronous up/down modulo-(MAXVAL+1) counter with clear, clamped load,
// cascade terminal count and sticky wrap flag. Define SYNCNT_UPDN_SAT_EN to saturate instead of wrap.
module syncnt_updn #(
    parameter int          WIDTH  = 4,
    parameter int unsigned MAXVAL = (2**WIDTH) - 1
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] q_o,
    output logic             tc_o,
    output logic             ovf_o
);

    localparam logic [WIDTH-1:0] MAX_C = MAXVAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

`ifdef SYNCNT_UPDN_SAT_EN
    localparam logic [WIDTH-1:0] UP_WRAP_C = MAX_C;
    localparam logic [WIDTH-1:0] DN_WRAP_C = '0;
`else
    localparam logic [WIDTH-1:0] UP_WRAP_C = '0;
    localparam logic [WIDTH-1:0] DN_WRAP_C = MAX_C;
`endif

    logic [WIDTH-1:0] q_q, q_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;

    assign at_max  = (q_q == MAX_C);
    assign at_zero = (q_q == '0);

    // Cascade enable: only a real counting edge at the boundary ripples onward.
    assign tc_o = en_i & ~clr_i & ~load_i & ((up_i & at_max) | (~up_i & at_zero));

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (load_i) begin
            q_d   = (d_i > MAX_C) ? MAX_C : d_i;
            ovf_d = 1'b0;
        end else if (en_i) begin
            if (up_i) begin
                if (at_max) begin
                    q_d   = UP_WRAP_C;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_q + ONE_C;
                end
            end else begin
                if (at_zero) begin
                    q_d   = DN_WRAP_C;
                    ovf_d = 1'b1;
                end else begin
                    q_d = q_q - ONE_C;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign q_o   = q_q;
    assign ovf_o = ovf_q;

endmodule
